// File: rtl/fetch_parcel_aligner.sv
// Fetch sequencer: word fetches split into 16-bit parcels, compressed parcels expanded, straddling 32-bit instructions rejoined.
// Response-to-instr_valid is 2 edges; instr_valid/instr_ready output slot holds its contents while decode stalls.
module fetch_parcel_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [15:0] decomp_in,
  input  logic [31:0] decomp_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_compressed
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t      state, state_nxt;
  logic [15:0] pbuf [3];
  logic [1:0]  count;
  logic [31:0] pc;
  logic [31:0] fetch_addr;
  logic        skip_first;
  logic        head_c;
  logic        need;
  logic        can_emit;
  logic        emit;
  logic        push;

  assign head_c    = (pbuf[0][1:0] != 2'b11);
  // Fetching only when the buffer cannot form an instruction keeps push and pop on different edges.
  assign need      = (count == 2'd0) || ((count == 2'd1) && !head_c);
  assign can_emit  = ((count != 2'd0) && head_c) || (count >= 2'd2);
  assign emit      = !flush && (!instr_valid || instr_ready) && can_emit;
  assign decomp_in = pbuf[0];
  assign mem_addr  = fetch_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (need && !flush && !reset) begin
          mem_req   = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mem_valid) begin
          push      = !flush;
          state_nxt = IDLE;
        end else if (flush) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (mem_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pbuf[0]    <= '0;
      pbuf[1]    <= '0;
      pbuf[2]    <= '0;
      count      <= 2'd0;
      pc         <= RESET_PC & ~32'd1;
      fetch_addr <= RESET_PC & ~32'd3;
      skip_first <= RESET_PC[1];
    end else if (flush) begin
      count      <= 2'd0;
      pc         <= flush_pc & ~32'd1;
      fetch_addr <= flush_pc & ~32'd3;
      skip_first <= flush_pc[1];
    end else begin
      if (mem_req) fetch_addr <= fetch_addr + 32'd4;
      if (push) begin
        // A redirect into the upper half of a word discards the lower parcel.
        if (skip_first) begin
          pbuf[count] <= mem_rdata[31:16];
          count       <= count + 2'd1;
          skip_first  <= 1'b0;
        end else begin
          pbuf[count]         <= mem_rdata[15:0];
          pbuf[count + 2'd1]  <= mem_rdata[31:16];
          count               <= count + 2'd2;
        end
      end else if (emit) begin
        if (head_c) begin
          pbuf[0] <= pbuf[1];
          pbuf[1] <= pbuf[2];
          count   <= count - 2'd1;
          pc      <= pc + 32'd2;
        end else begin
          pbuf[0] <= pbuf[2];
          count   <= count - 2'd2;
          pc      <= pc + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_valid      <= 1'b0;
      instr            <= '0;
      instr_pc         <= '0;
      instr_compressed <= 1'b0;
    end else if (flush) begin
      instr_valid <= 1'b0;
    end else if (emit) begin
      instr_valid      <= 1'b1;
      instr_pc         <= pc;
      instr_compressed <= head_c;
      instr            <= head_c ? decomp_out : {pbuf[1], pbuf[0]};
    end else if (instr_ready) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_parcel_aligner.sv
// Directed bench for fetch_parcel_aligner: memory responder, decompressor stub, emit/request logs.
module tb_fetch_parcel_aligner;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        flush;
  logic [31:0] flush_pc;
  logic [15:0] decomp_in;
  logic [31:0] decomp_out;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_compressed;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        comp;
  } emit_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          mem_lat = 0;
  int          first_req_cyc = -1;
  int          first_vld_cyc = -1;
  int          rel_cyc = 0;
  emit_t       got[$];
  logic [31:0] reqs[$];
  logic [31:0] mem [logic [31:0]];
  emit_t       exp_tab [8];

  fetch_parcel_aligner #(.RESET_PC(32'hFFFF_FFFC)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .flush(flush), .flush_pc(flush_pc),
    .decomp_in(decomp_in), .decomp_out(decomp_out),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_compressed(instr_compressed)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dec(input logic [15:0] p);
    return {p ^ 16'hA5A5, p};
  endfunction

  // Decompressor stub: any recognisable function of the parcel.
  assign decomp_out = dec(decomp_in);

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0001_0001;
  endfunction

  function automatic emit_t mk(input logic [31:0] pc, input logic [31:0] ins, input logic comp);
    emit_t e;
    e.pc = pc; e.ins = ins; e.comp = comp;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_emit(input string name, input int idx, input emit_t e);
    checks++;
    if (idx >= got.size()) begin
      failures++;
      $display("FAIL %s: emit %0d missing, expected pc=%h instr=%h c=%0b", name, idx, e.pc, e.ins, e.comp);
    end else if (got[idx].pc !== e.pc || got[idx].ins !== e.ins || got[idx].comp !== e.comp) begin
      failures++;
      $display("FAIL %s: emit %0d got pc=%h instr=%h c=%0b expected pc=%h instr=%h c=%0b",
               name, idx, got[idx].pc, got[idx].ins, got[idx].comp, e.pc, e.ins, e.comp);
    end
  endtask

  task automatic check_req(input string name, input int idx, input logic [31:0] a);
    if (idx >= reqs.size()) begin
      checks++;
      failures++;
      $display("FAIL %s: request %0d missing, expected addr %h", name, idx, a);
    end else begin
      check(name, reqs[idx], a);
    end
  endtask

  task automatic wait_got(input int n, input string name);
    int k = 0;
    while (got.size() < n && k < 300) begin
      @(posedge clk);
      k++;
    end
    check(name, 32'(got.size() >= n), 32'd1);
  endtask

  task automatic wait_req(input int n, input string name);
    int k = 0;
    while (reqs.size() < n && k < 300) begin
      @(posedge clk);
      k++;
    end
    check(name, 32'(reqs.size() >= n), 32'd1);
  endtask

  task automatic do_flush(input logic [31:0] a);
    @(posedge clk); #1;
    flush = 1'b1;
    flush_pc = a;
    @(posedge clk); #1;
    flush = 1'b0;
    got.delete();
    reqs.delete();
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory: one response per request, mem_lat extra cycles after the minimum.
  initial begin
    logic        pend;
    int          delay;
    logic [31:0] paddr;
    pend = 1'b0; delay = 0; paddr = '0;
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      if (pend) begin
        delay--;
        if (delay == 0) begin
          mem_valid = 1'b1;
          mem_rdata = mem_word(paddr);
          pend = 1'b0;
        end
      end
      if (!reset && mem_req) begin
        check("single_outstanding", 32'(pend), 32'd0);
        pend = 1'b1;
        delay = mem_lat + 1;
        paddr = mem_addr;
        reqs.push_back(mem_addr);
        if (first_req_cyc < 0) first_req_cyc = cyc;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset && instr_valid) begin
      if (first_vld_cyc < 0) first_vld_cyc = cyc;
      if (instr_ready) got.push_back(mk(instr_pc, instr, instr_compressed));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    mem[32'h0000_0000] = 32'h00B5_0533;
    mem[32'h0000_0004] = 32'h4501_0505;
    mem[32'h0000_0008] = 32'h0533_0505;
    mem[32'h0000_000C] = 32'h4501_00B5;
    mem[32'h0000_0020] = 32'h4501_0505;
    mem[32'h0000_0040] = 32'h0505_0505;
    mem[32'h0000_0060] = 32'h0505_0505;
    mem[32'h0000_0080] = 32'h00B5_0533;
    mem[32'h0000_0100] = 32'h4501_FFFF;

    exp_tab[0] = mk(32'hFFFF_FFFC, dec(16'h0001), 1'b1);
    exp_tab[1] = mk(32'hFFFF_FFFE, dec(16'h0001), 1'b1);
    exp_tab[2] = mk(32'h0000_0000, 32'h00B5_0533, 1'b0);
    exp_tab[3] = mk(32'h0000_0004, dec(16'h0505), 1'b1);
    exp_tab[4] = mk(32'h0000_0006, dec(16'h4501), 1'b1);
    exp_tab[5] = mk(32'h0000_0008, dec(16'h0505), 1'b1);
    exp_tab[6] = mk(32'h0000_000A, 32'h00B5_0533, 1'b0);
    exp_tab[7] = mk(32'h0000_000E, dec(16'h4501), 1'b1);

    reset = 1'b1;
    flush = 1'b0;
    flush_pc = '0;
    instr_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'hFFFF_FFFC);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_instr_compressed", 32'(instr_compressed), 32'd0);

    // Sequential stream from reset: wrap, aligned, paired compressed, straddling.
    instr_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rel_cyc = cyc;
    wait_got(8, "stream_timeout");
    for (int i = 0; i < 8; i++) check_emit("stream", i, exp_tab[i]);
    check("first_req_cycle", 32'(first_req_cyc), 32'(rel_cyc));
    check("first_latency", 32'(first_vld_cyc - first_req_cyc), 32'd3);
    check_req("req0_wrapstart", 0, 32'hFFFF_FFFC);
    check_req("req1_wrapped", 1, 32'h0000_0000);
    check_req("req2", 2, 32'h0000_0004);
    check_req("req3", 3, 32'h0000_0008);
    check_req("req4", 4, 32'h0000_000C);

    // Backpressure: first compressed parcel held for 5 cycles, no fetch meanwhile.
    @(posedge clk); #1;
    instr_ready = 1'b0;
    do_flush(32'h0000_0020);
    begin
      int k = 0;
      while (!instr_valid && k < 100) begin
        @(negedge clk);
        k++;
      end
      check("bp_valid_timeout", 32'(instr_valid), 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(instr_valid), 32'd1);
      check("bp_hold_instr", instr, dec(16'h0505));
      check("bp_hold_pc", instr_pc, 32'h0000_0020);
      check("bp_hold_comp", 32'(instr_compressed), 32'd1);
    end
    check("bp_req_count", 32'(reqs.size()), 32'd1);
    check_req("bp_req_addr", 0, 32'h0000_0020);
    @(posedge clk); #1;
    instr_ready = 1'b1;
    wait_got(2, "bp_release_timeout");
    check_emit("bp_emit", 0, mk(32'h0000_0020, dec(16'h0505), 1'b1));
    check_emit("bp_emit", 1, mk(32'h0000_0022, dec(16'h4501), 1'b1));

    // Flush while a slow request is outstanding; target in the upper half of a word.
    @(posedge clk); #1;
    instr_ready = 1'b0;
    mem_lat = 6;
    do_flush(32'h0000_0040);
    wait_req(1, "fo_req_timeout");
    check_req("fo_first_req", 0, 32'h0000_0040);
    do_flush(32'h0000_0102);
    mem_lat = 0;
    instr_ready = 1'b1;
    wait_got(2, "fo_emit_timeout");
    check_req("fo_redirect_req", 0, 32'h0000_0100);
    check_emit("fo_emit", 0, mk(32'h0000_0102, dec(16'h4501), 1'b1));
    check_emit("fo_emit", 1, mk(32'h0000_0104, dec(16'h0001), 1'b1));

    // Flush in the same cycle as the response.
    @(posedge clk); #1;
    instr_ready = 1'b0;
    mem_lat = 3;
    do_flush(32'h0000_0060);
    wait_req(1, "fr_req_timeout");
    check_req("fr_first_req", 0, 32'h0000_0060);
    begin
      int k = 0;
      logic seen;
      seen = 1'b0;
      while (!seen && k < 50) begin
        @(negedge clk); #2;
        seen = mem_valid;
        k++;
      end
      check("fr_resp_timeout", 32'(seen), 32'd1);
    end
    flush = 1'b1;
    flush_pc = 32'h0000_0080;
    @(posedge clk); #1;
    flush = 1'b0;
    got.delete();
    reqs.delete();
    mem_lat = 0;
    instr_ready = 1'b1;
    wait_got(1, "fr_emit_timeout");
    check_req("fr_redirect_req", 0, 32'h0000_0080);
    check_emit("fr_emit", 0, mk(32'h0000_0080, 32'h00B5_0533, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
